// File: rtl/match_score_if.sv
// Bus between the game logic and the match scorer.
// Every input is a level or a one-Clk pulse sampled on the Clk edge; the bus has no backpressure.
interface match_score_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 2
);
  localparam int IDX_W = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;

  logic                           frame_tick;
  logic [2:0]                     Game_State;
  logic [NUM_PLAYERS-1:0]         crash;
  logic                           new_match;
  logic [NUM_PLAYERS*SCORE_W-1:0] score;
  logic [NUM_PLAYERS-1:0]         alive;
  logic                           reset_round;
  logic [IDX_W-1:0]               round_winner;
  logic                           round_valid;
  logic                           round_draw;
  logic                           match_over;
  logic [IDX_W-1:0]               match_winner;
  logic [2:0]                     dbg_state;

  modport master (
    output frame_tick, Game_State, crash, new_match,
    input  score, alive, reset_round, round_winner, round_valid,
           round_draw, match_over, match_winner, dbg_state
  );

  modport slave (
    input  frame_tick, Game_State, crash, new_match,
    output score, alive, reset_round, round_winner, round_valid,
           round_draw, match_over, match_winner, dbg_state
  );
endinterface

// File: rtl/match_score.sv
// Light-cycle match scorer: tracks survivors per round, awards round wins after a
// settle window, and latches the match winner once a score reaches WIN_SCORE.
module match_score #(
  parameter int NUM_PLAYERS   = 2,
  parameter int SCORE_W       = 2,
  parameter int WIN_SCORE     = 3,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic          Clk,
  input  logic          Reset_Score,
  match_score_if.slave  bus
);
  localparam int IDX_W = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CNT_W = $clog2(SETTLE_FRAMES + 2);
  localparam int POP_W = IDX_W + 1;
  localparam logic [CNT_W-1:0]   SETTLE_LIM = CNT_W'(SETTLE_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_LIM    = SCORE_W'(WIN_SCORE);
  localparam logic [2:0]         GS_MENU    = 3'd0;
  localparam logic [2:0]         GS_PLAY    = 3'd2;

  typedef enum logic [2:0] {
    S_PLAY   = 3'd0,
    S_SETTLE = 3'd1,
    S_AWARD  = 3'd2,
    S_RRESET = 3'd3,
    S_WON    = 3'd4
  } state_t;

  state_t                               r_state;
  state_t                               w_state_nxt;
  logic [NUM_PLAYERS-1:0]               r_alive;
  logic [NUM_PLAYERS-1:0]               w_alive_upd;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]  r_score;
  logic [CNT_W-1:0]                     r_cnt;
  logic [CNT_W-1:0]                     w_cnt_nxt;
  logic [IDX_W-1:0]                     r_round_winner;
  logic [IDX_W-1:0]                     r_match_winner;
  logic [IDX_W-1:0]                     w_first_idx;
  logic                                 r_match_over;
  logic [POP_W-1:0]                     w_pop_upd;
  logic [POP_W-1:0]                     w_pop_cur;
  logic [SCORE_W-1:0]                   w_cur_score;
  logic [SCORE_W-1:0]                   w_inc_score;
  logic                                 w_menu;
  logic                                 w_playing;
  logic                                 w_sole;
  logic                                 w_reach;

  always_comb begin
    w_menu      = (bus.Game_State == GS_MENU);
    w_playing   = (bus.Game_State == GS_PLAY);
    w_alive_upd = w_playing ? (r_alive & ~bus.crash) : r_alive;
    w_cnt_nxt   = r_cnt + CNT_W'(bus.frame_tick);
    w_pop_upd   = '0;
    w_pop_cur   = '0;
    w_first_idx = '0;
    w_cur_score = '0;
    // Descending scan so the lowest surviving index wins the name lookup.
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      w_pop_upd = w_pop_upd + POP_W'(w_alive_upd[i]);
      w_pop_cur = w_pop_cur + POP_W'(r_alive[i]);
      if (w_alive_upd[i]) w_first_idx = IDX_W'(i);
      if (IDX_W'(i) == r_round_winner) w_cur_score = r_score[i];
    end
    w_inc_score = (w_cur_score >= WIN_LIM) ? w_cur_score : w_cur_score + 1'b1;
    w_sole      = (w_pop_cur == POP_W'(1));
    w_reach     = w_sole && (w_inc_score == WIN_LIM);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_PLAY:   if (w_pop_upd <= POP_W'(1)) w_state_nxt = S_SETTLE;
      S_SETTLE: if (w_cnt_nxt >= SETTLE_LIM) w_state_nxt = S_AWARD;
      S_AWARD:  w_state_nxt = w_reach ? S_WON : S_RRESET;
      S_RRESET: w_state_nxt = S_PLAY;
      S_WON:    if (bus.new_match) w_state_nxt = S_RRESET;
      default:  w_state_nxt = S_PLAY;
    endcase
    // Returning to the menu restarts everything from any state.
    if (w_menu) w_state_nxt = S_RRESET;
  end

  always_ff @(posedge Clk or posedge Reset_Score) begin
    if (Reset_Score) begin
      r_state <= S_PLAY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or posedge Reset_Score) begin
    if (Reset_Score) begin
      r_alive        <= '1;
      r_score        <= '0;
      r_cnt          <= '0;
      r_round_winner <= '0;
      r_match_winner <= '0;
      r_match_over   <= 1'b0;
    end else if (w_menu) begin
      r_alive      <= '1;
      r_score      <= '0;
      r_cnt        <= '0;
      r_match_over <= 1'b0;
    end else begin
      case (r_state)
        S_PLAY: begin
          r_alive <= w_alive_upd;
          r_cnt   <= '0;
        end
        S_SETTLE: begin
          r_alive <= w_alive_upd;
          r_cnt   <= w_cnt_nxt;
          if (w_state_nxt == S_AWARD) r_round_winner <= w_first_idx;
        end
        S_AWARD: begin
          if (w_sole) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              if (IDX_W'(i) == r_round_winner) r_score[i] <= w_inc_score;
            end
            if (w_reach) begin
              r_match_over   <= 1'b1;
              r_match_winner <= r_round_winner;
            end
          end
        end
        S_RRESET: r_alive <= '1;
        S_WON: begin
          if (bus.new_match) begin
            r_score      <= '0;
            r_alive      <= '1;
            r_match_over <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.score        = r_score;
  assign bus.alive        = r_alive;
  assign bus.round_winner = r_round_winner;
  assign bus.match_over   = r_match_over;
  assign bus.match_winner = r_match_winner;
  assign bus.round_valid  = (r_state == S_AWARD);
  assign bus.round_draw   = (r_state == S_AWARD) && (r_alive == '0);
  assign bus.reset_round  = (r_state == S_RRESET);
  assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_match_score.sv
// Bench for match_score: directed table, multi-cycle corner sequences, and a
// randomized run against a round-level reference model (two and four players).
module tb_match_score;
  localparam int WIN = 3;
  localparam int SF  = 2;

  logic Clk;
  logic Reset_Score;
  int   n_tests = 0;
  int   n_fail  = 0;

  match_score_if #(.NUM_PLAYERS(2), .SCORE_W(2)) bus2 ();
  match_score_if #(.NUM_PLAYERS(4), .SCORE_W(2)) bus4 ();

  match_score #(.NUM_PLAYERS(2), .SCORE_W(2), .WIN_SCORE(WIN), .SETTLE_FRAMES(SF)) dut2 (
    .Clk(Clk), .Reset_Score(Reset_Score), .bus(bus2)
  );
  match_score #(.NUM_PLAYERS(4), .SCORE_W(2), .WIN_SCORE(WIN), .SETTLE_FRAMES(SF)) dut4 (
    .Clk(Clk), .Reset_Score(Reset_Score), .bus(bus4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] gs;
    logic [1:0] crash;
    logic       tick;
    logic [1:0] e_alive;
    logic [3:0] e_score;
    logic       e_rv;
    logic       e_rd;
    logic       e_rr;
    logic       e_rw;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t v(logic [2:0] gs, logic [1:0] c, logic t, logic [1:0] ea,
                             logic [3:0] es, logic rv, logic rd, logic rr, logic rw);
    vec_t x;
    x.gs = gs; x.crash = c; x.tick = t; x.e_alive = ea; x.e_score = es;
    x.e_rv = rv; x.e_rd = rd; x.e_rr = rr; x.e_rw = rw;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle2();
    bus2.Game_State = 3'd2; bus2.crash = 2'b00; bus2.frame_tick = 1'b0; bus2.new_match = 1'b0;
  endtask

  // One round on the two-player unit: crash mask for one cycle, then frame ticks until
  // the award cycle appears (bounded).
  task automatic round2(input logic [1:0] cm, input logic exp_draw, input logic exp_w);
    int k;
    bus2.crash = cm;
    cyc();
    bus2.crash = 2'b00;
    bus2.frame_tick = 1'b1;
    k = 0;
    while (bus2.round_valid !== 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    bus2.frame_tick = 1'b0;
    check("round_seen", bus2.round_valid, 1);
    check("round_draw", bus2.round_draw, exp_draw);
    if (!exp_draw) check("round_winner", bus2.round_winner, exp_w);
  endtask

  // Reference model: survivors, settle window, award, restart and match win.
  logic [1:0] m_alive;
  int         m_score[2];
  bit         m_settle, m_award, m_restart, m_won;
  int         m_cnt, m_rw, m_mw;

  task automatic model_reset();
    m_alive = 2'b11; m_score[0] = 0; m_score[1] = 0;
    m_settle = 0; m_award = 0; m_restart = 0; m_won = 0;
    m_cnt = 0; m_rw = 0; m_mw = 0;
  endtask

  function automatic int lowest(input logic [1:0] a);
    for (int i = 0; i < 2; i++) if (a[i]) return i;
    return 0;
  endfunction

  task automatic model_step(input logic [2:0] gs, input logic [1:0] c, input logic t, input logic nm);
    if (gs == 3'd0) begin
      m_score[0] = 0; m_score[1] = 0; m_alive = 2'b11;
      m_settle = 0; m_award = 0; m_won = 0; m_cnt = 0; m_restart = 1;
    end else if (m_restart) begin
      m_restart = 0; m_alive = 2'b11;
    end else if (m_won) begin
      if (nm) begin
        m_score[0] = 0; m_score[1] = 0; m_alive = 2'b11; m_won = 0; m_restart = 1;
      end
    end else if (m_award) begin
      m_award = 0;
      if ($countones(m_alive) == 1) begin
        int w;
        w = lowest(m_alive);
        m_score[w] = (m_score[w] < WIN) ? m_score[w] + 1 : WIN;
        if (m_score[w] == WIN) begin
          m_won = 1; m_mw = w;
        end else begin
          m_restart = 1;
        end
      end else begin
        m_restart = 1;
      end
    end else if (m_settle) begin
      if (gs == 3'd2) m_alive = m_alive & ~c;
      if (t) m_cnt++;
      if (m_cnt >= SF) begin
        m_settle = 0; m_award = 1; m_rw = lowest(m_alive);
      end
    end else begin
      if (gs == 3'd2) m_alive = m_alive & ~c;
      if ($countones(m_alive) <= 1) begin
        m_settle = 1; m_cnt = 0;
      end
    end
  endtask

  initial begin
    tbl[0]  = v(3'd2, 2'b01, 1'b0, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = v(3'd2, 2'b00, 1'b1, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[2]  = v(3'd2, 2'b00, 1'b1, 2'b10, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[3]  = v(3'd2, 2'b00, 1'b0, 2'b10, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[4]  = v(3'd2, 2'b00, 1'b0, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = v(3'd2, 2'b11, 1'b0, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[6]  = v(3'd2, 2'b00, 1'b1, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[7]  = v(3'd2, 2'b00, 1'b1, 2'b00, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[8]  = v(3'd2, 2'b00, 1'b0, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[9]  = v(3'd2, 2'b00, 1'b0, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = v(3'd2, 2'b10, 1'b0, 2'b01, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[11] = v(3'd1, 2'b01, 1'b1, 2'b01, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[12] = v(3'd1, 2'b01, 1'b1, 2'b01, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[13] = v(3'd2, 2'b11, 1'b0, 2'b01, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[14] = v(3'd2, 2'b11, 1'b0, 2'b11, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[15] = v(3'd2, 2'b00, 1'b0, 2'b11, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clock/reset
    Reset_Score = 1'b1;
    idle2();
    bus4.Game_State = 3'd2; bus4.crash = 4'b0000; bus4.frame_tick = 1'b0; bus4.new_match = 1'b0;
    repeat (3) cyc();
    check("rst_alive", bus2.alive, 2'b11);
    check("rst_score", bus2.score, 4'b0000);
    check("rst_pulses", {bus2.round_valid, bus2.round_draw, bus2.reset_round}, 3'b000);
    check("rst_match", {bus2.match_over, bus2.match_winner, bus2.round_winner}, 3'b000);
    Reset_Score = 1'b0;

    // Table: single winner, simultaneous draw, paused settle, crashes ignored after award
    for (int i = 0; i < 16; i++) begin
      bus2.Game_State = tbl[i].gs;
      bus2.crash      = tbl[i].crash;
      bus2.frame_tick = tbl[i].tick;
      cyc();
      check($sformatf("tbl%0d_alive", i), bus2.alive, tbl[i].e_alive);
      check($sformatf("tbl%0d_score", i), bus2.score, tbl[i].e_score);
      check($sformatf("tbl%0d_pulses", i), {bus2.round_valid, bus2.round_draw, bus2.reset_round},
            {tbl[i].e_rv, tbl[i].e_rd, tbl[i].e_rr});
      if (tbl[i].e_rv && !tbl[i].e_rd) check($sformatf("tbl%0d_rw", i), bus2.round_winner, tbl[i].e_rw);
    end
    idle2();

    // Second crash inside the settle window turns the round into a draw
    bus2.crash = 2'b01; cyc();
    bus2.crash = 2'b00; bus2.frame_tick = 1'b1; cyc();
    bus2.crash = 2'b10; bus2.frame_tick = 1'b0; cyc();
    check("late_crash_alive", bus2.alive, 2'b00);
    bus2.crash = 2'b00; bus2.frame_tick = 1'b1; cyc();
    check("late_crash_draw", {bus2.round_valid, bus2.round_draw}, 2'b11);
    bus2.frame_tick = 1'b0; cyc();
    check("late_crash_score", bus2.score, 4'b0101);
    check("late_crash_rr", bus2.reset_round, 1);
    cyc();

    // Menu during play clears scores and pulses reset_round once
    bus2.Game_State = 3'd0; cyc();
    check("menu_score", bus2.score, 4'b0000);
    check("menu_rr", bus2.reset_round, 1);
    bus2.Game_State = 3'd2; cyc();
    check("menu_rr_off", bus2.reset_round, 0);
    check("menu_alive", bus2.alive, 2'b11);

    // Player 1 takes the match
    round2(2'b01, 1'b0, 1'b1); cyc(); cyc();
    round2(2'b01, 1'b0, 1'b1); cyc(); cyc();
    round2(2'b01, 1'b0, 1'b1);
    bus2.crash = 2'b10;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("won_over", bus2.match_over, 1);
      check("won_winner", bus2.match_winner, 1);
      check("won_score", bus2.score, 4'b1100);
      check("won_rr", bus2.reset_round, 0);
    end
    bus2.crash = 2'b00; bus2.new_match = 1'b1; cyc();
    bus2.new_match = 1'b0;
    check("newm_score", bus2.score, 4'b0000);
    check("newm_rr", bus2.reset_round, 1);
    check("newm_over", bus2.match_over, 0);
    cyc();
    check("newm_alive", bus2.alive, 2'b11);

    // Four players: winner only after the third crash and the settle window
    bus4.crash = 4'b0001; cyc();
    bus4.crash = 4'b0000; cyc();
    bus4.crash = 4'b0100; cyc();
    bus4.crash = 4'b0000; cyc();
    check("n4_alive2", bus4.alive, 4'b1010);
    check("n4_no_award2", bus4.round_valid, 0);
    bus4.crash = 4'b1000; cyc();
    bus4.crash = 4'b0000;
    check("n4_alive3", bus4.alive, 4'b0010);
    check("n4_no_award3", bus4.round_valid, 0);
    bus4.frame_tick = 1'b1; cyc();
    check("n4_no_award4", bus4.round_valid, 0);
    cyc();
    bus4.frame_tick = 1'b0;
    check("n4_award", {bus4.round_valid, bus4.round_draw}, 2'b10);
    check("n4_winner", bus4.round_winner, 1);
    cyc();
    check("n4_score", bus4.score, 8'b0000_0100);
    check("n4_rr", bus4.reset_round, 1);
    cyc();

    // Asynchronous reset in the middle of the settle window
    bus2.crash = 2'b01; cyc();
    bus2.crash = 2'b00;
    check("pre_rst_state", bus2.dbg_state, 3'd1);
    #2 Reset_Score = 1'b1;
    #1;
    check("async_alive", bus2.alive, 2'b11);
    check("async_state", bus2.dbg_state, 3'd0);
    check("async_score4", bus4.score, 8'h00);
    check("async_pulses", {bus2.round_valid, bus2.reset_round, bus2.match_over}, 3'b000);
    cyc();
    Reset_Score = 1'b0;
    model_reset();

    // Randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [3:0] e_sc;
      r = $urandom_range(0, 999);
      bus2.Game_State = (r < 3) ? 3'd0 : (r < 30) ? 3'd1 : (r < 60) ? 3'd3 : 3'd2;
      bus2.crash      = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus2.frame_tick = ($urandom_range(0, 3) == 0);
      bus2.new_match  = ($urandom_range(0, 19) == 0);
      model_step(bus2.Game_State, bus2.crash, bus2.frame_tick, bus2.new_match);
      cyc();
      e_sc = {2'(m_score[1]), 2'(m_score[0])};
      check("rnd_bundle",
            {bus2.alive, bus2.score, bus2.round_valid, bus2.round_draw, bus2.reset_round, bus2.match_over},
            {m_alive, e_sc, m_award, m_award && (m_alive == 2'b00), m_restart, m_won});
      if (m_award && m_alive != 2'b00) check("rnd_rw", bus2.round_winner, 32'(m_rw));
      if (m_won) check("rnd_mw", bus2.match_winner, 32'(m_mw));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
